// File: rtl/saes_encryptor.sv
// saes_encryptor: iterative S-AES encryption engine, one round per cycle.
// Key expansion runs inline with the rounds; all three round keys are
// exported alongside the ciphertext so a decryptor can be driven from them.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset (aborts any block in flight)
//   in_valid  - pt/key valid
//   in_ready  - engine idle and able to accept a block
//   pt        - plaintext, nibbles [15:12]=s00 [11:8]=s10 [7:4]=s01 [3:0]=s11
//   key       - cipher key (round key K0)
//   out_valid - ct/rk0/rk1/rk2 valid, held until out_ready
//   out_ready - downstream accepts the result
//   ct        - ciphertext (registered)
//   rk0..rk2  - round keys K0, K1, K2 (registered)
module saes_encryptor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] pt,
  input  logic [15:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ct,
  output logic [15:0] rk0,
  output logic [15:0] rk1,
  output logic [15:0] rk2
);

  typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] st;
  logic [7:0]  w2, w3, w4, w5;
  logic [15:0] r1_st, r2_ct;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
      4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
      4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
      4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] subnib8(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  function automatic logic [15:0] subnib16(input logic [15:0] x);
    return {subnib8(x[15:8]), subnib8(x[7:0])};
  endfunction

  function automatic logic [7:0] rotnib(input logic [7:0] x);
    return {x[3:0], x[7:4]};
  endfunction

  function automatic logic [15:0] shiftrow(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  // Multiply by x^2 in GF(2^4) mod x^4+x+1: two reduced doublings.
  function automatic logic [3:0] gf_mul4(input logic [3:0] x);
    logic [3:0] d;
    d = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    return {d[2:0], 1'b0} ^ (d[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [7:0] mixcol8(input logic [7:0] c);
    return {c[7:4] ^ gf_mul4(c[3:0]), gf_mul4(c[7:4]) ^ c[3:0]};
  endfunction

  function automatic logic [15:0] mixcol(input logic [15:0] x);
    return {mixcol8(x[15:8]), mixcol8(x[7:0])};
  endfunction

  // Round key and round datapaths; R1 expands from rk0, R2 from rk1.
  always_comb begin
    w2    = rk0[15:8] ^ 8'h80 ^ subnib8(rotnib(rk0[7:0]));
    w3    = w2 ^ rk0[7:0];
    w4    = rk1[15:8] ^ 8'h30 ^ subnib8(rotnib(rk1[7:0]));
    w5    = w4 ^ rk1[7:0];
    r1_st = mixcol(shiftrow(subnib16(st))) ^ {w2, w3};
    r2_ct = shiftrow(subnib16(st)) ^ {w4, w5};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = R1;
      end
      R1:      state_nxt = R2;
      R2:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      st        <= '0;
      ct        <= '0;
      rk0       <= '0;
      rk1       <= '0;
      rk2       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // Accept: initial AddRoundKey with K0
        IDLE: begin
          if (in_valid) begin
            st  <= pt ^ key;
            rk0 <= key;
          end
        end
        // Round 1: full round including MixColumns
        R1: begin
          rk1 <= {w2, w3};
          st  <= r1_st;
        end
        // Round 2: final round, no MixColumns
        R2: begin
          rk2       <= {w4, w5};
          ct        <= r2_ct;
          out_valid <= 1'b1;
        end
        // Hold results until the consumer takes them
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
